bus_ctrl: RTL and testbench
===========================

Name: bus_ctrl

Overview:
- Parametrised bus controller: decodes the CPU address into a chip-select and sequences each access with a per-region wait-state count or a slave acknowledge.
- Reports a bus error for unmapped addresses and for acknowledge timeouts.
- Sits between the CPU bus interface and all memory/IO slaves.
- Region table comes from parameters; the map input selects between the boot and run address maps.

Parameters:
- AW, 32, address width.
- CSW, 4, chip-select width; 0 means no select.
- NREG, 8, number of decode regions.
- REGION_BASE, NREG*AW packed, inclusive low bound per region. Region i occupies bits [i*AW +: AW].
- REGION_LIMIT, NREG*AW packed, inclusive high bound per region.
- REGION_CS, NREG*CSW packed, chip-select driven when the region hits.
- REGION_MODE, NREG*2 packed. Bit0 enables the region when map=0; bit1 enables it when map=1.
- REGION_WAIT, NREG*4 packed, fixed wait cycles (0-15) per region.
- REGION_ACK, NREG bits. 1 means the access completes on ack, not on the wait count.
- TIMEOUT, 255, maximum WAIT cycles allowed in ack mode before an error. Must be at least 1.
- Defaults (index: base-limit, cs, mode):
  - 0: 00000000-00003FFF, cs3, map0
  - 1: 00004000-007FFFFF, cs6, map0
  - 2: 00000000-007FFFFF, cs6, map1
  - 3: 00800000-008007FF, cs5, both
  - 4: 00800800-00800FFF, cs4, both
  - 5: FFFF8000-FFFFBFFF, cs3, map1
  - 6: FFFF0000-FFFFFFBF, cs2, both
  - 7: FFFFFFC0-FFFFFFFF, cs1, both
  - REGION_WAIT=1 for all regions; REGION_ACK=1 for region 4 only.

Ports:
- clock, input, 1: system clock; all logic on the rising edge.
- reset_n, input, 1: reset, synchronous, active-low.
- read, input, 1: read request; held high for the whole access.
- write, input, 1: write request; same rules as read.
- address, input, AW: access address.
- map, input, 1: address map select.
- ack, input, 1: slave completion; only sampled in WAIT for ack-mode regions.
- buswait, output, 1: stall to CPU; low only in DONE or ERR.
- start, output, 1: one-cycle address-latch strobe to slaves.
- chipselect, output, CSW: registered select of the current access.
- buserr, output, 1: access failed; high only in ERR.

Behaviour:
- Reset: on a clock edge with reset_n=0, state=IDLE, chipselect=0, both counters=0. Outputs during and after reset: start=0, buswait=1, buserr=0. Reset overrides all states, including mid-access.
- req = read | write. Read and write both high is treated as one access.
- Decode (combinational, IDLE only):
  - Region i hits when REGION_BASE[i] <= address <= REGION_LIMIT[i] and REGION_MODE[i][map]=1.
  - Lowest hit index wins.
  - No hit means unmapped.
- States: IDLE, START, WAIT, DONE, ERR.
- IDLE, when req=1:
  - If mapped: latch chipselect, wait count, ack flag and map from the hit region; next state START.
  - If unmapped: chipselect=0; next state ERR.
  - Address and map changes after leaving IDLE are ignored.
- START: start=1.
  - req=0 -> IDLE (abort; chipselect cleared).
  - Otherwise, fixed mode with WAIT=0 -> DONE.
  - Otherwise -> WAIT; load the wait counter with REGION_WAIT and clear the timeout counter.
- WAIT, fixed mode: decrement each cycle; after the cycle with counter==1 -> DONE. This gives exactly W cycles in WAIT.
- WAIT, ack mode:
  - ack=1 -> DONE.
  - Otherwise increment the timeout counter; on the TIMEOUT-th ack-less WAIT cycle -> ERR.
  - ack and timeout in the same cycle: ack wins.
- WAIT, either mode: req=0 -> IDLE (abort, chipselect cleared, no error).
- DONE: buswait=0. Stay while req=1; req=0 -> IDLE and chipselect cleared.
- ERR: buswait=0, buserr=1. Stay while req=1; req=0 -> IDLE.
- Back-to-back accesses require at least one cycle with req=0. A request held high never restarts.
- Latency, fixed mode, req first seen in IDLE at cycle n: START at n+1, DONE (buswait=0) at n+2+W. W=1 gives buswait low on the third cycle after the request.
- Counter widths: wait counter 4 bits; timeout counter clog2(TIMEOUT+1) bits. Neither wraps.

Test Plan:
- Reset pulse mid-WAIT -> next cycle state=IDLE, chipselect=0, buswait=1, start=0, buserr=0.
- map=0, read at 00001000, W=1 -> start high at n+1, chipselect=3 from n+1, buswait=0 at n+3. map=1, same address -> chipselect=6.
- map=1, write at FFFF9000 -> chipselect=3 (region 5 beats region 6). map=0, same address -> chipselect=2.
- read at 00900000 -> chipselect=0, buserr=1 and buswait=0 at n+1; drop read -> IDLE, buserr=0.
- IO read at 00800900 (ack mode):
  - ack raised on the 3rd WAIT cycle -> DONE on the next cycle.
  - No ack -> ERR after 255 WAIT cycles.
  - ack on cycle 255 -> DONE, not ERR.
- Drop read in START and again in WAIT -> IDLE, chipselect=0, no buserr. Change address during WAIT -> chipselect unchanged.

Source files
------------

// File: rtl/bus_ctrl.sv
// ---------------------------------------------------------------------------
// bus_ctrl
//   Bus controller between the CPU bus interface and the memory/IO slaves.
//   An access is decoded against a parameter-supplied region table, which
//   yields a chip-select. The access is then sequenced either by a fixed
//   per-region wait count or by waiting for the slave acknowledge. Unmapped
//   addresses and acknowledge timeouts are reported as a bus error.
//
// Handshake: the CPU raises read and/or write (req) and holds it for the
//   whole access. buswait stays high until the access ends in DONE or ERR.
//   The CPU then drops req, and the controller returns to IDLE on the next
//   edge. A new access needs at least one cycle with req low. Dropping req
//   before DONE/ERR aborts the access without raising an error.
//
// Ports:
//   clock       system clock, rising edge
//   reset_n     synchronous active-low reset
//   read        read request, held for the whole access
//   write       write request, same rules as read
//   address     access address (decoded in IDLE only)
//   map         address map select (0 = boot map, 1 = run map)
//   ack         slave completion, sampled in WAIT for ack-mode regions
//   buswait     stall to CPU, low only in DONE or ERR
//   start       one-cycle address-latch strobe to slaves
//   chipselect  registered select of the current access (0 = none)
//   buserr      access failed, high only in ERR
//   dbg_state   current FSM state (0 IDLE, 1 START, 2 WAIT, 3 DONE, 4 ERR)
// ---------------------------------------------------------------------------
module bus_ctrl #(
  parameter int AW   = 32,
  parameter int CSW  = 4,
  parameter int NREG = 8,
  parameter logic [NREG*AW-1:0] REGION_BASE = {
    32'hFFFFFFC0, 32'hFFFF0000, 32'hFFFF8000, 32'h00800800,
    32'h00800000, 32'h00000000, 32'h00004000, 32'h00000000},
  parameter logic [NREG*AW-1:0] REGION_LIMIT = {
    32'hFFFFFFFF, 32'hFFFFFFBF, 32'hFFFFBFFF, 32'h00800FFF,
    32'h008007FF, 32'h007FFFFF, 32'h007FFFFF, 32'h00003FFF},
  parameter logic [NREG*CSW-1:0] REGION_CS = {
    4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd3},
  parameter logic [NREG*2-1:0] REGION_MODE = {
    2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b01},
  parameter logic [NREG*4-1:0] REGION_WAIT = 32'h11111111,
  parameter logic [NREG-1:0]   REGION_ACK  = 8'b0001_0000,
  parameter int TIMEOUT = 255
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           read,
  input  logic           write,
  input  logic [AW-1:0]  address,
  input  logic           map,
  input  logic           ack,
  output logic           buswait,
  output logic           start,
  output logic [CSW-1:0] chipselect,
  output logic           buserr,
  output logic [2:0]     dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t         r_state;
  logic [CSW-1:0] r_cs;
  logic [3:0]     r_wcnt;
  logic [TW-1:0]  r_tcnt;
  logic           r_ackm;

  state_t         w_state_nxt;
  logic [CSW-1:0] w_cs_nxt;
  logic [3:0]     w_wcnt_nxt;
  logic [TW-1:0]  w_tcnt_nxt;
  logic           w_ackm_nxt;

  logic           w_req;
  logic           w_hit;
  logic [CSW-1:0] w_hit_cs;
  logic [3:0]     w_hit_wait;
  logic           w_hit_ack;

  assign w_req = read | write;

  // Region decode. Scanning from the top index down lets the lowest hitting
  // index overwrite the others, so it wins the priority.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_cs   = '0;
    w_hit_wait = '0;
    w_hit_ack  = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if ((address >= REGION_BASE[i*AW +: AW]) &&
          (address <= REGION_LIMIT[i*AW +: AW]) &&
          REGION_MODE[2*i + (map ? 1 : 0)]) begin
        w_hit      = 1'b1;
        w_hit_cs   = REGION_CS[i*CSW +: CSW];
        w_hit_wait = REGION_WAIT[i*4 +: 4];
        w_hit_ack  = REGION_ACK[i];
      end
    end
  end

  // State register, with the access context registers that travel with it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cs    <= '0;
      r_wcnt  <= '0;
      r_tcnt  <= '0;
      r_ackm  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cs    <= w_cs_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_ackm  <= w_ackm_nxt;
    end
  end

  // Next-state logic. The region wait count is latched into the wait
  // counter in IDLE and counted down in WAIT. The map select is consumed by
  // the decode and has no use after IDLE, so it is not kept.
  always_comb begin
    w_state_nxt = r_state;
    w_cs_nxt    = r_cs;
    w_wcnt_nxt  = r_wcnt;
    w_tcnt_nxt  = r_tcnt;
    w_ackm_nxt  = r_ackm;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_cs_nxt    = w_hit_cs;
            w_wcnt_nxt  = w_hit_wait;
            w_ackm_nxt  = w_hit_ack;
            w_state_nxt = S_START;
          end else begin
            w_cs_nxt    = '0;
            w_state_nxt = S_ERR;
          end
        end
      end
      S_START: begin
        if (!w_req) begin
          w_cs_nxt    = '0;
          w_state_nxt = S_IDLE;
        end else if (!r_ackm && (r_wcnt == 4'd0)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_tcnt_nxt  = '0;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_cs_nxt    = '0;
          w_state_nxt = S_IDLE;
        end else if (r_ackm) begin
          // ack beats a timeout landing in the same cycle.
          if (ack) begin
            w_state_nxt = S_DONE;
          end else begin
            w_tcnt_nxt = r_tcnt + TW'(1);
            if (r_tcnt == TW'(TIMEOUT - 1)) begin
              w_state_nxt = S_ERR;
            end
          end
        end else begin
          // The counter is never 0 here; <= 1 keeps it from wrapping anyway.
          if (r_wcnt <= 4'd1) begin
            w_state_nxt = S_DONE;
          end else begin
            w_wcnt_nxt = r_wcnt - 4'd1;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (!w_req) begin
          w_cs_nxt    = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_cs_nxt    = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded purely from the registered state.
  always_comb begin
    start      = (r_state == S_START);
    buswait    = !((r_state == S_DONE) || (r_state == S_ERR));
    buserr     = (r_state == S_ERR);
    chipselect = r_cs;
    dbg_state  = r_state;
  end

endmodule

// File: tb/tb_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_ctrl
//   Self-checking bench for bus_ctrl with the default region table.
//   The reference model works on an access timeline: from the region that
//   the address hits, it computes the cycle on which START, DONE or ERR
//   begins, counted from the cycle in which the request is first seen.
// ---------------------------------------------------------------------------
module tb_bus_ctrl;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset_n;
  logic        read, write, map, ack;
  logic [31:0] address;
  logic        buswait, start, buserr;
  logic [3:0]  chipselect;
  logic [2:0]  dbg_state;

  always #5 clock = ~clock;

  bus_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .read       (read),
    .write      (write),
    .address    (address),
    .map        (map),
    .ack        (ack),
    .buswait    (buswait),
    .start      (start),
    .chipselect (chipselect),
    .buserr     (buserr),
    .dbg_state  (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference region table ----------------
  logic [31:0] base_t  [8] = '{32'h00000000, 32'h00004000, 32'h00000000, 32'h00800000,
                               32'h00800800, 32'hFFFF8000, 32'hFFFF0000, 32'hFFFFFFC0};
  logic [31:0] limit_t [8] = '{32'h00003FFF, 32'h007FFFFF, 32'h007FFFFF, 32'h008007FF,
                               32'h00800FFF, 32'hFFFFBFFF, 32'hFFFFFFBF, 32'hFFFFFFFF};
  int          cs_t    [8] = '{3, 6, 6, 5, 4, 3, 2, 1};
  bit          on0_t   [8] = '{1, 1, 0, 1, 1, 0, 1, 1};
  bit          on1_t   [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
  int          wait_t  [8] = '{1, 1, 1, 1, 1, 1, 1, 1};
  bit          ack_t   [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
  localparam int TMO = 255;

  // Lowest matching region index, or -1 if unmapped.
  function automatic int decode(input logic [31:0] a, input logic m);
    for (int i = 0; i < 8; i++) begin
      if (a >= base_t[i] && a <= limit_t[i] && (m ? on1_t[i] : on0_t[i])) return i;
    end
    return -1;
  endfunction

  // Expected {start, buswait, buserr, chipselect} in cycle k of an access.
  // k=0 is the cycle the request is first presented; req drops in cycle a;
  // ack is high only in cycle k_ack.
  function automatic logic [6:0] expect_out(input int k, input int r, input int a, input int k_ack);
    logic [3:0] cs;
    int done_k;
    if (k == 0 || k > a) return {1'b0, 1'b1, 1'b0, 4'd0};
    if (r < 0) return {1'b0, 1'b0, 1'b1, 4'd0};
    cs = 4'(cs_t[r]);
    if (k == 1) return {1'b1, 1'b1, 1'b0, cs};
    if (!ack_t[r]) begin
      done_k = 2 + wait_t[r];
    end else if (k_ack >= 2 && (k_ack - 1) <= TMO) begin
      // ack on WAIT cycle j (= cycle 1+j) finishes on the next cycle
      done_k = k_ack + 1;
    end else begin
      // TMO ack-less WAIT cycles (cycles 2..TMO+1), ERR afterwards
      return (k < 2 + TMO) ? {1'b0, 1'b1, 1'b0, cs} : {1'b0, 1'b0, 1'b1, cs};
    end
    return (k < done_k) ? {1'b0, 1'b1, 1'b0, cs} : {1'b0, 1'b0, 1'b0, cs};
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input int k, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {start, buswait, buserr, chipselect};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed={start,buswait,buserr,cs}=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Runs one access through cycles 0..a+1, driving inputs #1 after the
  // rising edge and checking on the falling edge. Address and map are
  // scrambled after cycle 0 since only the cycle-0 values may matter.
  task automatic run_access(input logic [31:0] addr, input logic m, input int rw,
                            input int k_ack, input int a, input string tag);
    int r;
    r = decode(addr, m);
    for (int k = 0; k <= a + 1; k++) begin
      @(posedge clock); #1;
      if (k == 0) begin
        address = addr;
        map     = m;
      end else begin
        address = $urandom;
        map     = 1'($urandom_range(0, 1));
      end
      read  = (k < a) && rw[0];
      write = (k < a) && rw[1];
      ack   = (k == k_ack);
      @(negedge clock);
      check(tag, k, expect_out(k, r, a, k_ack));
    end
    ack = 1'b0;
  endtask

  // Hard time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int          sel, ri;
    logic [31:0] addr, span;

    reset_n = 1'b0;
    read = 1'b1; write = 1'b0; map = 1'b0; ack = 1'b0;
    address = 32'h00001000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_hold", 0, {1'b0, 1'b1, 1'b0, 4'd0});
    read = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("after_reset", 0, {1'b0, 1'b1, 1'b0, 4'd0});

    // fixed-wait latency and map select
    run_access(32'h00001000, 1'b0, 1, 0, 6, "map0_rd_1000");
    run_access(32'h00001000, 1'b1, 1, 0, 5, "map1_rd_1000");
    // priority: region 5 beats region 6 in map 1
    run_access(32'hFFFF9000, 1'b1, 2, 0, 5, "map1_wr_ffff9000");
    run_access(32'hFFFF9000, 1'b0, 2, 0, 5, "map0_wr_ffff9000");
    run_access(32'h00900000, 1'b0, 1, 0, 3, "unmapped");
    run_access(32'h00800900, 1'b0, 3, 0, 3, "rdwr_both_unmapped_chk");
    // ack mode
    run_access(32'h00800900, 1'b0, 1, 4, 8, "ack_wait3");
    run_access(32'h00800900, 1'b0, 1, 0, 260, "ack_timeout");
    run_access(32'h00800900, 1'b1, 1, 256, 260, "ack_at_255");
    run_access(32'h00800900, 1'b0, 1, 1, 6, "ack_in_start_ignored");
    // aborts
    run_access(32'h00001000, 1'b0, 1, 0, 1, "abort_start");
    run_access(32'h00800900, 1'b0, 1, 0, 3, "abort_wait");
    // decode boundaries
    run_access(32'h00003FFF, 1'b0, 1, 0, 4, "bnd_3fff");
    run_access(32'h00004000, 1'b0, 1, 0, 4, "bnd_4000");
    run_access(32'h00800FFF, 1'b0, 1, 2, 4, "bnd_800fff");
    run_access(32'h00801000, 1'b0, 1, 0, 3, "bnd_801000");
    run_access(32'hFFFFFFBF, 1'b0, 1, 0, 4, "bnd_ffffffbf");
    run_access(32'hFFFFFFC0, 1'b0, 1, 0, 4, "bnd_ffffffc0");
    run_access(32'h00004000, 1'b1, 1, 0, 4, "bnd_4000_map1");

    // reset pulse in the middle of WAIT
    @(posedge clock); #1;
    address = 32'h00800900; map = 1'b0; read = 1'b1;
    @(posedge clock); #1;
    address = 32'h00001000;
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(negedge clock);
    check("wait_before_reset", 2, {1'b0, 1'b1, 1'b0, 4'd4});
    @(posedge clock); #1;
    reset_n = 1'b1;
    read = 1'b0;
    @(negedge clock);
    check("after_mid_reset", 3, {1'b0, 1'b1, 1'b0, 4'd0});

    // randomized accesses
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7) begin
        ri   = $urandom_range(0, 7);
        span = limit_t[ri] - base_t[ri] + 32'd1;
        case ($urandom_range(0, 3))
          0:       addr = base_t[ri];
          1:       addr = limit_t[ri];
          default: addr = base_t[ri] + ($urandom % span);
        endcase
      end else if (sel == 7) begin
        addr = $urandom;
      end else begin
        addr = 32'h00900000 + 32'($urandom_range(0, 4095));
      end
      run_access(addr, 1'($urandom_range(0, 1)), $urandom_range(1, 3),
                 $urandom_range(0, 8), $urandom_range(1, 10), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
